// File: rtl/uart_rx_engine_pkg.sv
// Shared types and helpers for the UART receive engine and its bit timer.
// The baud table is also meant for the transmit engine.
package uart_rx_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic [3:0] baud;
    logic       eight;
    logic       pen;
    logic       ohel;
  } rx_mode_t;

  localparam int unsigned BAUD_MIN = 32'd300;

  function automatic int unsigned baud_rate(input logic [3:0] sel);
    int unsigned rate;
    case (sel)
      4'd0:    rate = 32'd300;
      4'd1:    rate = 32'd1200;
      4'd2:    rate = 32'd2400;
      4'd3:    rate = 32'd4800;
      4'd4:    rate = 32'd9600;
      4'd5:    rate = 32'd19200;
      4'd6:    rate = 32'd38400;
      4'd7:    rate = 32'd57600;
      4'd8:    rate = 32'd115200;
      4'd9:    rate = 32'd230400;
      4'd10:   rate = 32'd460800;
      default: rate = 32'd921600;
    endcase
    return rate;
  endfunction

  // Expected parity bit: even sense makes the total count of ones even.
  function automatic logic parity_expected(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_engine_bit_timer.sv
// Bit-time down-counter: decodes the baud select into K = CLK_FREQ/rate and
// reloads with a full or half bit; tick_o is high while the count sits at zero.
module uart_rx_engine_bit_timer
  import uart_rx_engine_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] baud_sel_i,
  input  logic       load_half_i,
  input  logic       load_full_i,
  output logic       tick_o
);

  localparam int unsigned CW = $clog2(CLK_FREQ / BAUD_MIN + 32'd1);

  logic [CW-1:0] k_tab [16];
  logic [CW-1:0] k_s;
  logic [CW-1:0] h_s;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  for (genvar g = 0; g < 16; g++) begin : g_k_tab
    assign k_tab[g] = CW'(CLK_FREQ / baud_rate(4'(g)));
  end

  // Loads count K-1 / H-1 so a tick recurs every K cycles.
  always_comb begin
    k_s = k_tab[baud_sel_i];
    h_s = k_s >> 1;
    if (load_full_i) begin
      cnt_d = k_s - CW'(1'b1);
    end else if (load_half_i) begin
      cnt_d = h_s - CW'(1'b1);
    end else if (cnt_q != {CW{1'b0}}) begin
      cnt_d = cnt_q - CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= {CW{1'b0}};
      tick_o <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      tick_o <= (cnt_d == {CW{1'b0}});
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: rx synchronizer, start/data/parity/stop FSM and the
// holding register with ready/error/overrun flags and a per-frame interrupt.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       rx,
  input  logic       clear_rx,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       rx_int
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  rx_state_e              state_q;
  rx_mode_t               mode_q;
  logic                   armed_q;
  logic                   stop_q;
  logic [3:0]             bit_cnt_q;
  logic [8:0]             shift_q;
  logic                   tick;
  logic                   start_seen;
  logic                   load_half;
  logic                   load_full;
  logic [3:0]             baud_sel;
  logic [3:0]             last_bit;
  logic [7:0]             data_s;
  logic                   parity_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Until the frame starts the live baud input drives the timer so the half-bit load uses it.
  always_comb begin
    start_seen = (state_q == ST_IDLE) && armed_q && !rxs;
    baud_sel   = (state_q == ST_IDLE) ? baud : mode_q.baud;
    load_half  = start_seen;
    load_full  = tick && (((state_q == ST_START) && !rxs) || (state_q == ST_DATA));
    last_bit   = 4'd6 + {3'd0, mode_q.eight} + {3'd0, mode_q.pen};
    if (mode_q.eight) begin
      data_s   = shift_q[7:0];
      parity_s = shift_q[8];
    end else begin
      data_s   = {1'b0, shift_q[6:0]};
      parity_s = shift_q[7];
    end
  end

  uart_rx_engine_bit_timer #(
    .CLK_FREQ(CLK_FREQ)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .baud_sel_i (baud_sel),
    .load_half_i(load_half),
    .load_full_i(load_full),
    .tick_o     (tick)
  );

  // Frame FSM plus holding register; armed_q blocks re-triggering while a break holds rx low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      armed_q   <= 1'b0;
      stop_q    <= 1'b0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 9'd0;
      rx_data   <= 8'd0;
      rxrdy     <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      ovf       <= 1'b0;
      rx_int    <= 1'b0;
    end else begin
      rx_int <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_seen) begin
            mode_q    <= {baud, eight, pen, ohel};
            armed_q   <= 1'b0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 9'd0;
            state_q   <= ST_START;
          end else if (rxs) begin
            armed_q <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= rxs ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            // Bits land at their final position: data LSB first, parity just above.
            shift_q[bit_cnt_q] <= rxs;
            if (bit_cnt_q == last_bit) begin
              state_q <= ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            stop_q  <= rxs;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (state_q == ST_DONE) begin
        rx_data <= data_s;
        rxrdy   <= 1'b1;
        rx_int  <= 1'b1;
        perr    <= mode_q.pen & (parity_s != parity_expected(data_s, mode_q.ohel));
        ferr    <= ~stop_q;
        ovf     <= ovf | (rxrdy & ~clear_rx);
      end else if (clear_rx) begin
        rxrdy <= 1'b0;
        perr  <= 1'b0;
        ferr  <= 1'b0;
        ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frames are driven bit by bit on rx, and a
// frame-level model predicts every output on every cycle.
module tb_uart_rx_engine;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int SYNC = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] baud = 4'd8;
  logic       eight = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       rx = 1'b1;
  logic       clear_rx = 1'b0;
  logic [7:0] rx_data;
  logic       rxrdy, perr, ferr, ovf, rx_int;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int clr_at = -10;
  logic chk_en = 1'b0;
  logic rst_seen = 1'b1;
  logic clr_seen = 1'b0;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;
  frame_t exp_q[$];

  logic [7:0] m_data = 8'd0;
  logic m_rdy = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0, m_int = 1'b0;

  uart_rx_engine #(.CLK_FREQ(CLK_FREQ), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .baud(baud), .eight(eight), .pen(pen), .ohel(ohel),
    .rx(rx), .clear_rx(clear_rx), .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr),
    .ferr(ferr), .ovf(ovf), .rx_int(rx_int)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
    clr_seen <= clear_rx;
  end

  initial forever begin
    @(negedge clock);
    clear_rx = (cyc == clr_at);
  end

  function automatic int bit_time(input logic [3:0] sel);
    int rate;
    case (sel)
      4'd0: rate = 300;      4'd1: rate = 1200;     4'd2: rate = 2400;
      4'd3: rate = 4800;     4'd4: rate = 9600;     4'd5: rate = 19200;
      4'd6: rate = 38400;    4'd7: rate = 57600;    4'd8: rate = 115200;
      4'd9: rate = 230400;   4'd10: rate = 460800;  default: rate = 921600;
    endcase
    return CLK_FREQ / rate;
  endfunction

  // Frame-level model: a frame takes effect on its due cycle, clear_rx otherwise clears flags.
  always @(negedge clock) begin
    if (rst_seen) begin
      m_data = 8'd0; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0; m_int = 1'b0;
      exp_q.delete();
    end else begin
      m_int = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_ovf  = m_ovf | (m_rdy & ~clr_seen);
        m_data = exp_q[0].data;
        m_rdy  = 1'b1;
        m_perr = exp_q[0].perr;
        m_ferr = exp_q[0].ferr;
        m_int  = 1'b1;
        void'(exp_q.pop_front());
      end else if (clr_seen) begin
        m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
      end
    end
    if (rx_int === 1'b1) pulses++;
    if (chk_en) begin
      total++;
      if ({rx_data, rxrdy, perr, ferr, ovf, rx_int} !== {m_data, m_rdy, m_perr, m_ferr, m_ovf, m_int}) begin
        bad++;
        $display("FAIL cycle_check cyc=%0d got data=%h rdy=%b perr=%b ferr=%b ovf=%b int=%b want data=%h rdy=%b perr=%b ferr=%b ovf=%b int=%b",
                 cyc, rx_data, rxrdy, perr, ferr, ovf, rx_int, m_data, m_rdy, m_perr, m_ferr, m_ovf, m_int);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clr_at = cyc + 1;
    repeat (3) @(negedge clock);
  endtask

  // Drives one frame; the stop bit is sampled H + (N-1)*K cycles after rxs falls,
  // and the registered outputs appear two cycles later.
  task automatic send_frame(input logic [7:0] d, input logic e8, input logic pe, input logic odd,
                            input logic par_bit, input logic stop_bit, input logic [3:0] bsel,
                            input int tail_low, input int rst_bit, input logic chg_mid,
                            input logic clr_done);
    int k, h, nd, nb, c;
    logic [10:0] bits;
    logic [7:0] dm;
    frame_t f;
    k  = bit_time(bsel);
    h  = k / 2;
    nd = e8 ? 8 : 7;
    dm = e8 ? d : {1'b0, d[6:0]};
    bits = 11'd0;
    for (int i = 0; i < nd; i++) bits[1 + i] = d[i];
    if (pe) bits[1 + nd] = par_bit;
    nb = 1 + nd + (pe ? 1 : 0) + 1;
    bits[nb - 1] = stop_bit;
    @(negedge clock);
    baud = bsel; eight = e8; pen = pe; ohel = odd;
    @(negedge clock);
    c = cyc;
    f.due  = c + SYNC + h + (nb - 1) * k + 2;
    f.data = dm;
    f.perr = pe & (par_bit != ((^dm) ^ odd));
    f.ferr = ~stop_bit;
    exp_q.push_back(f);
    if (clr_done) clr_at = f.due - 1;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      if (chg_mid && i == 4) begin
        baud = ~bsel; eight = ~e8; pen = ~pe; ohel = ~odd;
      end
      if (i == rst_bit) begin
        repeat (k / 2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (k - k / 2 - 4) @(negedge clock);
      end else begin
        repeat (k) @(negedge clock);
      end
    end
    if (tail_low > 0) repeat (tail_low) @(negedge clock);
    rx = 1'b1;
    repeat (2 * k) @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_data", rx_data, 8'h00);
    chk("reset_flags", {3'd0, rxrdy, perr, ferr, ovf, rx_int}, 8'h00);
    repeat (5) @(negedge clock);

    // 8N1 0xA5 at 115200
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 0, -1, 1'b0, 1'b0);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h08);
    chk("a5_pulses", 8'(pulses), 8'd1);
    pulse_clear();
    chk("a5_clear", {4'd0, rxrdy, perr, ferr, ovf}, 8'h00);

    // 7-bit odd parity 0x41: correct parity bit 1, then wrong parity bit 0
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10, 0, -1, 1'b0, 1'b0);
    chk("p_ok_data", rx_data, 8'h41);
    chk("p_ok_perr", {7'd0, perr}, 8'h00);
    pulse_clear();
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 0, -1, 1'b0, 1'b0);
    chk("p_bad_data", rx_data, 8'h41);
    chk("p_bad_perr", {7'd0, perr}, 8'h01);
    pulse_clear();

    // 0x3C with stop bit 0 and rx held low afterwards
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 2 * bit_time(4'd10), -1, 1'b0, 1'b0);
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h0A);
    chk("ferr_pulses", 8'(pulses), 8'd4);

    // 200-cycle glitch at 115200: no frame, flags untouched
    @(negedge clock);
    baud = 4'd8;
    rx = 1'b0;
    repeat (200) @(negedge clock);
    rx = 1'b1;
    repeat (1500) @(negedge clock);
    chk("glitch_pulses", 8'(pulses), 8'd4);
    chk("glitch_flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h0A);
    pulse_clear();

    // 0x55 at 921600 with mode inputs changed mid-frame
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 0, -1, 1'b1, 1'b0);
    chk("mid_chg_data", rx_data, 8'h55);
    pulse_clear();

    // overrun: 0x11 then 0x22 without a read
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 0, -1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 0, -1, 1'b0, 1'b0);
    chk("ovf_data", rx_data, 8'h22);
    chk("ovf_flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h09);
    pulse_clear();
    chk("ovf_clear", {4'd0, rxrdy, perr, ferr, ovf}, 8'h00);
    chk("ovf_clear_data", rx_data, 8'h22);

    // reset in the middle of data bit 5 of 0xF0, then 0x0F
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 0, 6, 1'b0, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_pulses", 8'(pulses), 8'd7);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 0, -1, 1'b0, 1'b0);
    chk("post_rst_data", rx_data, 8'h0F);
    chk("post_rst_rdy", {7'd0, rxrdy}, 8'h01);

    // clear_rx coinciding with frame completion while rxrdy is set
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 0, -1, 1'b0, 1'b1);
    chk("clr_done_data", rx_data, 8'h7E);
    chk("clr_done_flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h08);
    chk("total_pulses", 8'(pulses), 8'd9);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
